l2_write_buffer: RTL and testbench



---
 rtl/l2_wb_pkg.sv | 23 ++
 rtl/l2_write_buffer.sv | 190 +++++++++++++++++++
 tb/tb_l2_write_buffer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/l2_wb_pkg.sv
// Shared types and constants for the L2 posted write buffer.
package l2_wb_pkg;

   localparam int unsigned WB_ADDR_W = 32;
   localparam int unsigned WB_DATA_W = 32;
   localparam int unsigned WB_BE_W   = WB_DATA_W / 8;

   // Byte-enable pattern of a full-word write; only these entries can forward.
   localparam logic [WB_BE_W-1:0] WB_BE_FULL = '1;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] addr;
      logic [WB_DATA_W-1:0] wdata;
      logic [WB_BE_W-1:0]   byte_en;
   } wb_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_DRAIN,
      RD_MEM
   } wb_state_t;

endpackage

// File: rtl/l2_write_buffer.sv
// Posted write buffer between the L2 memory-side bus and the memory controller.
// Writes are absorbed into an in-order FIFO and drained one at a time; reads
// either forward from a full-word buffered write or wait behind the drain.
// ADDR_WIDTH/DATA_WIDTH must match the entry widths in l2_wb_pkg.
module l2_write_buffer
   import l2_wb_pkg::*;
#(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
   parameter int unsigned DATA_WIDTH = WB_DATA_W
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [ADDR_WIDTH-1:0]   l2_addr,
   input  logic [DATA_WIDTH-1:0]   l2_wdata,
   input  logic                    l2_ren,
   input  logic                    l2_wen,
   input  logic [DATA_WIDTH/8-1:0] l2_byte_en,
   output logic [DATA_WIDTH-1:0]   l2_rdata,
   output logic                    l2_busy,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic                    mem_ren,
   output logic                    mem_wen,
   output logic [DATA_WIDTH/8-1:0] mem_byte_en,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    mem_busy,
   input  logic                    flush,
   output logic                    flush_done
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   wb_entry_t        fifo_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   wb_state_t        state_q, state_d;
   logic             flush_seen_q, flush_seen_d;

   wb_entry_t        head_e;
   logic             drain_en;
   logic             push;
   logic             pop;

   logic             fwd_hit;
   logic             fwd_full;
   logic [DATA_WIDTH-1:0] fwd_data;

   // Drain engine: head entry is offered to memory whenever no read owns the bus.
   always_comb begin
      head_e   = fifo_q[head_q];
      drain_en = (state_q != RD_MEM) && (count_q != '0);
      pop      = drain_en && !mem_busy;
      // Full check uses the registered count so mem_busy never reaches write-accept.
      push     = (state_q == IDLE) && l2_wen && (count_q < CNT_FULL) && !flush;
   end

   // Pointer and occupancy bookkeeping for simultaneous push/pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push) begin
         tail_d = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Forward search: walk oldest to youngest so the last valid match wins;
   // the head is included even when it pops this cycle.
   always_comb begin
      logic [PTR_W-1:0] idx;
      idx      = '0;
      fwd_hit  = 1'b0;
      fwd_full = 1'b0;
      fwd_data = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = head_q + PTR_W'(k);
         if ((CNT_W'(k) < count_q) && (fifo_q[idx].addr == l2_addr)) begin
            fwd_hit  = 1'b1;
            fwd_full = (fifo_q[idx].byte_en == WB_BE_FULL);
            fwd_data = fifo_q[idx].wdata;
         end
      end
   end

   // Request-side FSM next state and the zero-latency L2 response.
   always_comb begin
      state_d  = state_q;
      l2_busy  = 1'b1;
      l2_rdata = '0;
      unique case (state_q)
         IDLE: begin
            if (l2_wen) begin
               if (push) begin
                  l2_busy = 1'b0;
               end
            end else if (l2_ren) begin
               if (fwd_hit && fwd_full) begin
                  l2_busy  = 1'b0;
                  l2_rdata = fwd_data;
               end else if (fwd_hit || (count_q != '0)) begin
                  state_d = RD_DRAIN;
               end else begin
                  state_d = RD_MEM;
               end
            end
         end
         RD_DRAIN: begin
            if (count_d == '0) begin
               state_d = RD_MEM;
            end
         end
         RD_MEM: begin
            if (!mem_busy) begin
               l2_busy  = 1'b0;
               l2_rdata = mem_rdata;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (RST) begin
         l2_busy  = 1'b1;
         l2_rdata = '0;
      end
   end

   // Memory-side request mux: RD_MEM owns the bus for the read, otherwise the drain.
   always_comb begin
      mem_ren     = (state_q == RD_MEM);
      mem_wen     = drain_en;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_byte_en = '0;
      if (state_q == RD_MEM) begin
         mem_addr = l2_addr;
      end else if (drain_en) begin
         mem_addr    = head_e.addr;
         mem_wdata   = head_e.wdata;
         mem_byte_en = head_e.byte_en;
      end
   end

   // Flush handshake: one pulse per flush assertion once the buffer is empty.
   always_comb begin
      flush_done   = flush && (state_q == IDLE) && (count_q == '0) &&
                     !flush_seen_q && !RST;
      flush_seen_d = flush && (flush_seen_q || flush_done);
   end

   // State, pointer and flag registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         flush_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         flush_seen_q <= flush_seen_d;
      end
   end

   // Entry storage, written at the tail on an accepted L2 write.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else if (push) begin
         fifo_q[tail_q] <= '{addr: l2_addr, wdata: l2_wdata, byte_en: l2_byte_en};
      end
   end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed self-checking bench for l2_write_buffer.
module tb_l2_write_buffer;

   logic        CLK;
   logic        RST;
   logic [31:0] l2_addr;
   logic [31:0] l2_wdata;
   logic        l2_ren;
   logic        l2_wen;
   logic [3:0]  l2_byte_en;
   logic [31:0] l2_rdata;
   logic        l2_busy;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ren;
   logic        mem_wen;
   logic [3:0]  mem_byte_en;
   logic [31:0] mem_rdata;
   logic        mem_busy;
   logic        flush;
   logic        flush_done;

   int checks;
   int errors;

   l2_write_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .l2_addr    (l2_addr),
      .l2_wdata   (l2_wdata),
      .l2_ren     (l2_ren),
      .l2_wen     (l2_wen),
      .l2_byte_en (l2_byte_en),
      .l2_rdata   (l2_rdata),
      .l2_busy    (l2_busy),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ren    (mem_ren),
      .mem_wen    (mem_wen),
      .mem_byte_en(mem_byte_en),
      .mem_rdata  (mem_rdata),
      .mem_busy   (mem_busy),
      .flush      (flush),
      .flush_done (flush_done)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive one L2 write at the next negedge (inputs held through the posedge).
   task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge CLK);
      l2_wen = 1'b1; l2_ren = 1'b0; l2_addr = a; l2_wdata = d; l2_byte_en = be;
      #1;
   endtask

   task automatic idle_bus();
      l2_wen = 1'b0; l2_ren = 1'b0; l2_addr = '0; l2_wdata = '0; l2_byte_en = '0;
   endtask

   task automatic test_reset();
      l2_wen = 1'b1; l2_addr = 32'h50; l2_wdata = 32'h1; l2_byte_en = 4'hF;
      #1;
      checks++; if (l2_busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", l2_busy); end
      checks++; if (mem_wen !== 1'b0 || mem_ren !== 1'b0) begin errors++; $display("FAIL rst_memreq got wen=%b ren=%b exp 0/0", mem_wen, mem_ren); end
      checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_byte_en !== 4'h0) begin errors++; $display("FAIL rst_membus got %h %h %h exp 0", mem_addr, mem_wdata, mem_byte_en); end
      checks++; if (l2_rdata !== 32'h0 || flush_done !== 1'b0) begin errors++; $display("FAIL rst_l2out got rdata=%h fd=%b exp 0/0", l2_rdata, flush_done); end
      @(negedge CLK);
      idle_bus();
      RST = 1'b0;
      #1;
      checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rst_release_wen got %b exp 0", mem_wen); end
   endtask

   task automatic test_posted_writes();
      mem_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_write(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
         checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL post_accept%0d got busy=%b exp 0", i, l2_busy); end
      end
      drive_write(32'h110, 32'hA4, 4'hF);
      checks++; if (l2_busy !== 1'b1) begin errors++; $display("FAIL post_full_stall got busy=%b exp 1", l2_busy); end
      checks++; if (mem_wen !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hA0) begin errors++; $display("FAIL post_head got wen=%b %h %h exp 1 100 a0", mem_wen, mem_addr, mem_wdata); end
      // First pop this cycle: the full buffer still refuses the write.
      @(negedge CLK); mem_busy = 1'b0; #1;
      checks++; if (l2_busy !== 1'b1) begin errors++; $display("FAIL post_pop_nopush got busy=%b exp 1", l2_busy); end
      @(negedge CLK); #1;
      checks++; if (l2_busy !== 1'b0) begin errors++; $display("FAIL post_late_accept got busy=%b exp 0", l2_busy); end
      checks++; if (mem_addr !== 32'h104 || mem_wdata !== 32'hA1) begin errors++; $display("FAIL post_order1 got %h %h exp 104 a1", mem_addr, mem_wdata); end
      @(negedge CLK); idle_bus(); #1;
      checks++; if (mem_addr !== 32'h108 || mem_wdata !== 32'hA2) begin errors++; $display("FAIL post_order2 got %h %h exp 108 a2", mem_addr, mem_wdata); end
      @(negedge CLK); #1;
      checks++; if (mem_addr !== 32'h10C || mem_wdata !== 32'hA3) begin errors++; $display("FAIL post_order3 got %h %h exp 10c a3", mem_addr, mem_wdata); end
      @(negedge CLK); #1;
      checks++; if (mem_wen !== 1'b1 || mem_addr !== 32'h110 || mem_wdata !== 32'hA4) begin errors++; $display("FAIL post_order4 got wen=%b %h %h exp 1 110 a4", mem_wen, mem_addr, mem_wdata); end
      @(negedge CLK); #1;
      checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL post_empty got wen=%b exp 0", mem_wen); end
   endtask

   task automatic test_forward();
      mem_busy = 1'b1;
      drive_write(32'h200, 32'h11, 4'hF);
      drive_write(32'h200, 32'h22, 4'hF);
      @(negedge CLK);
      l2_wen = 1'b0; l2_ren = 1'b1; l2_addr = 32'h200; #1;
      checks++; if (l2_busy !== 1'b0 || l2_rdata !== 32'h22) begin errors++; $display("FAIL fwd_data got busy=%b rdata=%h exp 0 22", l2_busy, l2_rdata); end
      checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL fwd_no_memrd got %b exp 0", mem_ren); end
      @(negedge CLK); idle_bus(); mem_busy = 1'b0; #1;
      checks++; if (mem_ren !== 1'b0 || mem_wdata !== 32'h11) begin errors++; $display("FAIL fwd_drain1 got ren=%b wdata=%h exp 0 11", mem_ren, mem_wdata); end
      @(negedge CLK); #1;
      checks++; if (mem_ren !== 1'b0 || mem_wdata !== 32'h22) begin errors++; $display("FAIL fwd_drain2 got ren=%b wdata=%h exp 0 22", mem_ren, mem_wdata); end
      @(negedge CLK); #1;
      checks++; if (mem_wen !== 1'b0 || mem_ren !== 1'b0) begin errors++; $display("FAIL fwd_idle got wen=%b ren=%b exp 0 0", mem_wen, mem_ren); end
   endtask

   task automatic test_partial();
      mem_busy = 1'b1;
      drive_write(32'h300, 32'h55, 4'h3);
      @(negedge CLK);
      l2_wen = 1'b0; l2_ren = 1'b1; l2_addr = 32'h300; #1;
      checks++; if (l2_busy !== 1'b1 || mem_ren !== 1'b0 || mem_wen !== 1'b1) begin errors++; $display("FAIL part_nofwd got busy=%b ren=%b wen=%b exp 1 0 1", l2_busy, mem_ren, mem_wen); end
      @(negedge CLK); mem_busy = 1'b0; #1;
      checks++; if (mem_wen !== 1'b1 || mem_addr !== 32'h300 || mem_byte_en !== 4'h3 || l2_busy !== 1'b1) begin errors++; $display("FAIL part_drain got wen=%b %h be=%h busy=%b exp 1 300 3 1", mem_wen, mem_addr, mem_byte_en, l2_busy); end
      @(negedge CLK); mem_busy = 1'b1; #1;
      checks++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_addr !== 32'h300 || l2_busy !== 1'b1) begin errors++; $display("FAIL part_memrd got ren=%b wen=%b %h busy=%b exp 1 0 300 1", mem_ren, mem_wen, mem_addr, l2_busy); end
      @(negedge CLK); mem_busy = 1'b0; mem_rdata = 32'hDEADBEEF; #1;
      checks++; if (l2_busy !== 1'b0 || l2_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL part_rdata got busy=%b rdata=%h exp 0 deadbeef", l2_busy, l2_rdata); end
      @(negedge CLK); idle_bus(); mem_rdata = '0; #1;
      checks++; if (mem_ren !== 1'b0) begin errors++; $display("FAIL part_done got ren=%b exp 0", mem_ren); end
   endtask

   task automatic test_empty_read();
      mem_busy = 1'b1;
      @(negedge CLK);
      l2_ren = 1'b1; l2_addr = 32'h400; #1;
      checks++; if (l2_busy !== 1'b1 || mem_ren !== 1'b0) begin errors++; $display("FAIL empty_first got busy=%b ren=%b exp 1 0", l2_busy, mem_ren); end
      @(negedge CLK); #1;
      checks++; if (mem_ren !== 1'b1 || mem_addr !== 32'h400 || l2_busy !== 1'b1) begin errors++; $display("FAIL empty_memrd got ren=%b %h busy=%b exp 1 400 1", mem_ren, mem_addr, l2_busy); end
      @(negedge CLK); mem_busy = 1'b0; mem_rdata = 32'hCAFEF00D; #1;
      checks++; if (l2_busy !== 1'b0 || l2_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL empty_rdata got busy=%b rdata=%h exp 0 cafef00d", l2_busy, l2_rdata); end
      @(negedge CLK); idle_bus(); mem_rdata = '0; #1;
      checks++; if (mem_ren !== 1'b0 || l2_rdata !== 32'h0) begin errors++; $display("FAIL empty_done got ren=%b rdata=%h exp 0 0", mem_ren, l2_rdata); end
   endtask

   task automatic test_flush();
      mem_busy = 1'b1;
      drive_write(32'h500, 32'h1, 4'hF);
      drive_write(32'h504, 32'h2, 4'hF);
      @(negedge CLK);
      flush = 1'b1; l2_wen = 1'b1; l2_addr = 32'h508; l2_wdata = 32'h3; #1;
      checks++; if (l2_busy !== 1'b1 || flush_done !== 1'b0) begin errors++; $display("FAIL flush_stall got busy=%b fd=%b exp 1 0", l2_busy, flush_done); end
      @(negedge CLK); mem_busy = 1'b0; #1;
      checks++; if (l2_busy !== 1'b1 || mem_addr !== 32'h500) begin errors++; $display("FAIL flush_drain1 got busy=%b %h exp 1 500", l2_busy, mem_addr); end
      @(negedge CLK); #1;
      checks++; if (mem_addr !== 32'h504 || flush_done !== 1'b0) begin errors++; $display("FAIL flush_drain2 got %h fd=%b exp 504 0", mem_addr, flush_done); end
      @(negedge CLK); #1;
      checks++; if (flush_done !== 1'b1 || mem_wen !== 1'b0 || l2_busy !== 1'b1) begin errors++; $display("FAIL flush_pulse got fd=%b wen=%b busy=%b exp 1 0 1", flush_done, mem_wen, l2_busy); end
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK); #1;
         checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL flush_single%0d got fd=%b exp 0", i, flush_done); end
      end
      @(negedge CLK); flush = 1'b0; #1;
      checks++; if (l2_busy !== 1'b0 || flush_done !== 1'b0) begin errors++; $display("FAIL flush_resume got busy=%b fd=%b exp 0 0", l2_busy, flush_done); end
      @(negedge CLK); idle_bus(); #1;
      checks++; if (mem_wen !== 1'b1 || mem_addr !== 32'h508) begin errors++; $display("FAIL flush_after got wen=%b %h exp 1 508", mem_wen, mem_addr); end
      @(negedge CLK); flush = 1'b1; #1;
      checks++; if (flush_done !== 1'b1) begin errors++; $display("FAIL flush_rearm got fd=%b exp 1", flush_done); end
      @(negedge CLK); flush = 1'b0; #1;
   endtask

   task automatic test_reset_mid();
      mem_busy = 1'b1;
      drive_write(32'h600, 32'h6, 4'hF);
      drive_write(32'h604, 32'h7, 4'hF);
      drive_write(32'h608, 32'h8, 4'hF);
      @(negedge CLK); idle_bus(); #1;
      checks++; if (mem_wen !== 1'b1 || mem_addr !== 32'h600) begin errors++; $display("FAIL rmid_pre got wen=%b %h exp 1 600", mem_wen, mem_addr); end
      #1; RST = 1'b1; l2_wen = 1'b1; l2_addr = 32'h700; #1;
      checks++; if (mem_wen !== 1'b0 || mem_addr !== 32'h0 || l2_busy !== 1'b1) begin errors++; $display("FAIL rmid_async got wen=%b %h busy=%b exp 0 0 1", mem_wen, mem_addr, l2_busy); end
      @(negedge CLK); idle_bus(); RST = 1'b0; mem_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (mem_wen !== 1'b0 || mem_ren !== 1'b0) begin errors++; $display("FAIL rmid_idle%0d got wen=%b ren=%b exp 0 0", i, mem_wen, mem_ren); end
         @(negedge CLK);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      RST = 1'b0; flush = 1'b0; mem_busy = 1'b1; mem_rdata = '0;
      idle_bus();
      #1 RST = 1'b1;
      test_reset();
      test_posted_writes();
      test_forward();
      test_partial();
      test_empty_read();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time bound so a stuck sequence still ends the run.
   initial begin
      #100000;
      $display("FAIL timeout got stuck exp finish");
      $fatal(1);
   end

endmodule
